game_state_ctrl: RTL and testbench

//  Parametrised game-flow controller for the VGA asteroid game: TITLE/PLAY/HIT/PAUSE/OVER FSM, lives and

---
 rtl/game_state_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Game-flow controller for the VGA asteroid game.
// It runs the TITLE/PLAY/HIT/PAUSE/OVER state machine and keeps the lives and score counts.
// It also provides a per-frame move strobe, the post-hit invulnerability window and the
// game-over button hold-off.
// All state advances only on clk edges qualified by the 25 MHz pixel enable.
module game_state_ctrl #(
    parameter int NUM_AST       = 3,
    parameter int LIVES         = 3,
    parameter int SCORE_W       = 8,
    parameter int INVULN_FRAMES = 60,
    parameter int OVER_HOLD     = 120,
    localparam int LIVES_W      = $clog2(LIVES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pixpulse,
    input  logic               vblank,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic [NUM_AST-1:0] hit,
    input  logic [NUM_AST-1:0] score_inc,
    output logic [2:0]         state,
    output logic               move,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic               invuln
);

    localparam int INV_W  = $clog2(INVULN_FRAMES + 1);
    localparam int HOLD_W = $clog2(OVER_HOLD + 1);

    typedef enum logic [2:0] {
        ST_TITLE = 3'd0,
        ST_PLAY  = 3'd1,
        ST_HIT   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Number of set bits in a strobe vector (at most 8 channels).
    function automatic logic [3:0] popcount(input logic [NUM_AST-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < NUM_AST; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    state_e               state_q, state_d;
    logic                 move_q, move_d;
    logic                 invuln_q, invuln_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [INV_W-1:0]     inv_q, inv_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 vblank_d1_q;
    logic [3:0]           btn_prev_q;

    logic [3:0]           btn_s;
    logic [3:0]           press_s;
    logic                 frame_s;
    logic [SCORE_W+3:0]   sum_s;
    logic [SCORE_W-1:0]   score_add_s;

    // Button order within the vectors: {up, down, left, right}.
    assign btn_s   = {btn_up, btn_down, btn_left, btn_right};
    assign press_s = btn_s & ~btn_prev_q;
    assign frame_s = vblank & ~vblank_d1_q;

    // Saturating score increment from this pixel's score strobes.
    always_comb begin
        sum_s = {4'b0000, score_q} + {{SCORE_W{1'b0}}, popcount(score_inc)};
        if (sum_s > {4'b0000, {SCORE_W{1'b1}}}) begin
            score_add_s = {SCORE_W{1'b1}};
        end else begin
            score_add_s = sum_s[SCORE_W-1:0];
        end
    end

    // Next-state, bookkeeping and output decode for the game flow.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        inv_d   = inv_q;
        hold_d  = hold_q;

        // Score only accumulates while the ship is on the field.
        if ((state_q == ST_PLAY) || (state_q == ST_HIT)) begin
            score_d = score_add_s;
        end else begin
            score_d = score_q;
        end

        case (state_q)
            ST_TITLE: begin
                if (|press_s) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_W'(LIVES);
                    score_d = {SCORE_W{1'b0}};
                end else begin
                    state_d = ST_TITLE;
                end
            end
            ST_PLAY: begin
                // A collision takes priority over a simultaneous pause press.
                if (|hit) begin
                    lives_d = lives_q - {{(LIVES_W-1){1'b0}}, 1'b1};
                    if (lives_q == {{(LIVES_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_OVER;
                        hold_d  = HOLD_W'(OVER_HOLD);
                    end else begin
                        state_d = ST_HIT;
                        inv_d   = INV_W'(INVULN_FRAMES);
                    end
                end else if (press_s[2]) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_HIT: begin
                if (frame_s) begin
                    if (inv_q == {{(INV_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_PLAY;
                        inv_d   = {INV_W{1'b0}};
                    end else begin
                        inv_d   = inv_q - {{(INV_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    inv_d = inv_q;
                end
            end
            ST_PAUSE: begin
                if (press_s[2]) begin
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_OVER: begin
                if (hold_q != {HOLD_W{1'b0}}) begin
                    if (frame_s) begin
                        hold_d = hold_q - {{(HOLD_W-1){1'b0}}, 1'b1};
                    end else begin
                        hold_d = hold_q;
                    end
                end else if (press_s[3]) begin
                    // Up wins over a simultaneous right press.
                    state_d = ST_TITLE;
                end else if (press_s[0]) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_W'(LIVES);
                    score_d = {SCORE_W{1'b0}};
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_TITLE;
                lives_d = {LIVES_W{1'b0}};
                score_d = {SCORE_W{1'b0}};
                inv_d   = {INV_W{1'b0}};
                hold_d  = {HOLD_W{1'b0}};
            end
        endcase

        move_d   = frame_s && ((state_q == ST_PLAY) || (state_q == ST_HIT));
        invuln_d = (state_d == ST_HIT);
    end

    // State, counters, edge detectors and registered outputs, advanced on pixel enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_TITLE;
            move_q      <= 1'b0;
            invuln_q    <= 1'b0;
            lives_q     <= {LIVES_W{1'b0}};
            score_q     <= {SCORE_W{1'b0}};
            inv_q       <= {INV_W{1'b0}};
            hold_q      <= {HOLD_W{1'b0}};
            vblank_d1_q <= 1'b0;
            btn_prev_q  <= 4'b0000;
        end else if (pixpulse) begin
            state_q     <= state_d;
            move_q      <= move_d;
            invuln_q    <= invuln_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            inv_q       <= inv_d;
            hold_q      <= hold_d;
            vblank_d1_q <= vblank;
            btn_prev_q  <= btn_s;
        end else begin
            state_q     <= state_q;
            move_q      <= move_q;
            invuln_q    <= invuln_q;
            lives_q     <= lives_q;
            score_q     <= score_q;
            inv_q       <= inv_q;
            hold_q      <= hold_q;
            vblank_d1_q <= vblank_d1_q;
            btn_prev_q  <= btn_prev_q;
        end
    end

    assign state  = state_q;
    assign move   = move_q;
    assign lives  = lives_q;
    assign score  = score_q;
    assign invuln = invuln_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: default instance plus a 4-bit-score instance
// sharing the same stimulus for the saturation case.
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pixpulse = 1'b0;
    logic       vblank = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [2:0] hit = 3'b000;
    logic [2:0] score_inc = 3'b000;

    logic [2:0] state, state4;
    logic       move, move4;
    logic [1:0] lives, lives4;
    logic [7:0] score;
    logic [3:0] score4;
    logic       invuln, invuln4;

    int total = 0;
    int bad   = 0;

    game_state_ctrl dut (
        .clk(clk), .rst_n(rst_n), .pixpulse(pixpulse), .vblank(vblank),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .hit(hit), .score_inc(score_inc),
        .state(state), .move(move), .lives(lives), .score(score), .invuln(invuln)
    );

    game_state_ctrl #(.SCORE_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pixpulse(pixpulse), .vblank(vblank),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .hit(hit), .score_inc(score_inc),
        .state(state4), .move(move4), .lives(lives4), .score(score4), .invuln(invuln4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One pixel period: a single enabled clock edge followed by three idle ones.
    task automatic tick();
        pixpulse = 1'b1;
        @(posedge clk); #1;
        pixpulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vblank = 1'b1; tick();
            vblank = 1'b0; tick();
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_lives", lives, 0);
        check("rst_score", score, 0);
        check("rst_move", move, 0);
        check("rst_invuln", invuln, 0);
        rst_n = 1'b1;
        tick();
        check("title_idle", state, 0);

        // Any press starts the game
        btn_left = 1'b1; tick();
        check("start_state", state, 1);
        check("start_lives", lives, 3);
        check("start_score", score, 0);
        btn_left = 1'b0; tick();

        // Move strobe: one pixel wide per vblank rise
        vblank = 1'b1; tick();
        check("move_hi", move, 1);
        tick();
        check("move_once", move, 0);
        vblank = 1'b0; tick();
        check("move_lo", move, 0);

        // Score popcount
        score_inc = 3'b101; tick();
        check("score_2", score, 2);
        score_inc = 3'b000;

        // Double hit plus score same pixel: one life, score still adds
        hit = 3'b011; score_inc = 3'b001; tick();
        check("hit1_lives", lives, 2);
        check("hit1_state", state, 2);
        check("hit1_invuln", invuln, 1);
        check("hit1_score", score, 3);
        hit = 3'b100; score_inc = 3'b000; tick();
        check("hit_ignored", lives, 2);
        hit = 3'b000;
        btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
        check("hit_btn_ignored", state, 2);

        // Invulnerability lasts 60 frames; move still pulses in HIT
        vblank = 1'b1; tick();
        check("hit_move", move, 1);
        vblank = 1'b0; tick();
        frames(58);
        check("inv_59", state, 2);
        frames(1);
        check("inv_60", state, 1);
        check("inv_clear", invuln, 0);

        // Second and third hits
        hit = 3'b001; tick(); hit = 3'b000;
        check("hit2_lives", lives, 1);
        frames(60);
        check("hit2_back", state, 1);
        hit = 3'b010; tick(); hit = 3'b000;
        check("hit3_lives", lives, 0);
        check("hit3_state", state, 4);
        check("hit3_invuln", invuln, 0);
        vblank = 1'b1; tick();
        check("over_nomove", move, 0);
        vblank = 1'b0; tick();

        // Game-over hold: presses ignored for 120 frames
        btn_right = 1'b1; tick(); btn_right = 1'b0; tick();
        check("hold_right", state, 4);
        frames(118);
        btn_right = 1'b1; tick(); btn_right = 1'b0; tick();
        check("hold_119", state, 4);
        frames(1);
        btn_up = 1'b1; btn_right = 1'b1; tick();
        check("up_right", state, 0);
        check("up_right_lives", lives, 0);
        btn_up = 1'b0; btn_right = 1'b0; tick();

        // Restart and saturate the 4-bit score instance
        btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
        check("restart_state", state, 1);
        check("restart_score", score, 0);
        score_inc = 3'b111;
        tick(); check("sat_3", score4, 3);
        tick(); check("sat_6", score4, 6);
        tick(); check("sat_9", score4, 9);
        tick(); check("sat_12", score4, 12);
        tick(); check("sat_15", score4, 15);
        tick(); check("sat_hold", score4, 15);
        score_inc = 3'b000;
        check("wide_18", score, 18);

        // Pause freezes everything
        btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
        check("pause_state", state, 3);
        hit = 3'b111; score_inc = 3'b111; tick();
        hit = 3'b000; score_inc = 3'b000;
        check("pause_score", score, 18);
        check("pause_lives", lives, 3);
        check("pause_state2", state, 3);
        vblank = 1'b1; tick();
        check("pause_nomove", move, 0);
        vblank = 1'b0; tick();
        btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
        check("resume_state", state, 1);
        check("resume_score", score, 18);
        check("resume_lives", lives, 3);

        // Hit and pause press together: hit wins
        hit = 3'b001; btn_down = 1'b1; tick();
        hit = 3'b000; btn_down = 1'b0; tick();
        check("hitwin_state", state, 2);
        check("hitwin_lives", lives, 2);
        frames(60);
        check("hitwin_back", state, 1);

        // Asynchronous reset mid-PLAY with a frame pending
        vblank = 1'b1; tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_state", state, 0);
        check("midrst_lives", lives, 0);
        check("midrst_score", score, 0);
        check("midrst_move", move, 0);
        check("midrst_invuln", invuln, 0);
        vblank = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_move", move, 0);
        check("post_rst_state", state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
